// File: rtl/wbuf_pkg.sv
// Shared definitions for the victim write buffer.
//   - Write/read type encodings used on the cache-side and bridge-side buses.
//   - Queued entry layout {type, addr, wstrb, data}, 167 bits total.
//   - Line-offset width and the helper that extracts a 16-byte line tag.
package wbuf_pkg;

  localparam logic [2:0] WR_TYPE_LINE = 3'b100;  // 16-byte cache line
  localparam logic [2:0] WR_TYPE_WORD = 3'b010;  // single 32-bit word

  localparam int ENTRY_W  = 167;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = 32 - OFFSET_W;

  typedef struct packed {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wbuf_entry_t;

  function automatic logic [TAG_W-1:0] line_tag(input logic [31:0] addr);
    return addr[31:OFFSET_W];
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Entry storage and pointers for the victim write buffer.
// Ports:
//   clk, reset        clock and synchronous active-high reset (control only)
//   push, pop         enqueue din at tail / dequeue head; push while full and
//                     pop while empty are ignored
//   din, dout         entry in, head entry out
//   count             number of queued entries, 0..DEPTH
//   valid, tags       per-slot occupancy and line tag, for address compares
module wbuf_fifo
  import wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  wbuf_entry_t                        din,
  output wbuf_entry_t                        dout,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0]                   valid,
  output logic [DEPTH-1:0][TAG_W-1:0]        tags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wbuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A write arriving while full is a protocol violation: drop it entirely.
  assign push_ok = push && (count < FULL_CNT);
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  // A slot is live when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    tags  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
      tags[i]  = line_tag(mem[i].addr);
    end
  end

endmodule

// File: rtl/victim_wbuf.sv
// Victim write buffer between the cache and the memory bridge.
// Cache writes (lines and uncached words) are queued and drained to the bridge
// in order. Reads pass through to the bridge, optionally held back while a
// queued write targets the same 16-byte line.
// Build option: define WBUF_RAW_CHECK_EN to enable the read-after-write line
// compare; without it reads are never held and ordering is left to the bridge.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   c_wr_req/type/addr/wstrb/data   cache write pulse and payload
//   c_wr_rdy                        room for one more write
//   c_rd_req/type/addr, c_rd_rdy    cache read request and acceptance
//   m_rd_req/type/addr, m_rd_rdy    gated read toward the bridge
//   m_wr_req/type/addr/wstrb/data   head entry toward the bridge
//   m_wr_rdy                        bridge takes the head entry
//   wb_empty                        nothing queued
module victim_wbuf
  import wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c_wr_req,
  input  logic [2:0]   c_wr_type,
  input  logic [31:0]  c_wr_addr,
  input  logic [3:0]   c_wr_wstrb,
  input  logic [127:0] c_wr_data,
  output logic         c_wr_rdy,
  input  logic         c_rd_req,
  input  logic [2:0]   c_rd_type,
  input  logic [31:0]  c_rd_addr,
  output logic         c_rd_rdy,
  output logic         m_rd_req,
  output logic [2:0]   m_rd_type,
  output logic [31:0]  m_rd_addr,
  input  logic         m_rd_rdy,
  output logic         m_wr_req,
  output logic [2:0]   m_wr_type,
  output logic [31:0]  m_wr_addr,
  output logic [3:0]   m_wr_wstrb,
  output logic [127:0] m_wr_data,
  input  logic         m_wr_rdy,
  output logic         wb_empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wbuf_entry_t                 wr_entry;
  wbuf_entry_t                 head;
  logic [CNT_W-1:0]            count;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][TAG_W-1:0] tags;
  logic                        hazard;

  assign wr_entry = '{typ: c_wr_type, addr: c_wr_addr, wstrb: c_wr_wstrb, data: c_wr_data};

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (c_wr_req),
    .pop   (m_wr_req && m_wr_rdy),
    .din   (wr_entry),
    .dout  (head),
    .count (count),
    .valid (valid),
    .tags  (tags)
  );

  assign c_wr_rdy   = count < CNT_W'(DEPTH);
  assign m_wr_req   = count != '0;
  assign wb_empty   = count == '0;
  assign m_wr_type  = head.typ;
  assign m_wr_addr  = head.addr;
  assign m_wr_wstrb = head.wstrb;
  assign m_wr_data  = head.data;

`ifdef WBUF_RAW_CHECK_EN
  // Compare against registered occupancy, so an entry popping this cycle still
  // blocks the read; the hold releases the cycle after it leaves.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == line_tag(c_rd_addr))) hazard = 1'b1;
    end
    hazard = hazard && c_rd_req;
  end
`else
  logic unused_raw;
  assign unused_raw = ^{valid, tags};
  assign hazard     = 1'b0;
`endif

  assign m_rd_req  = c_rd_req && !hazard;
  assign c_rd_rdy  = m_rd_rdy && !hazard;
  assign m_rd_type = c_rd_type;
  assign m_rd_addr = c_rd_addr;

endmodule
